// File: rtl/bsg_link_osdr_pkg.sv
// Shared state encoding and PHY word helpers for the OSDR transmit sequencer.
package bsg_link_osdr_pkg;

  typedef enum logic [1:0] {
    PHY_RST = 2'd0,
    WARMUP  = 2'd1,
    ACTIVE  = 2'd2
  } bsg_link_osdr_tx_state_e;

  // Widest payload the word builder supports; callers cast the result down.
  localparam int unsigned PHY_MAX_W = 1024;
  localparam int unsigned PHY_IDX_W = $clog2(PHY_MAX_W + 1);

  localparam logic [PHY_MAX_W:0] PHY_IDLE_WORD = '0;

  // Places the valid flag directly above a width-bit payload.
  function automatic logic [PHY_MAX_W:0] phy_word(
    input logic                   valid,
    input logic [PHY_MAX_W-1:0]   payload,
    input logic [PHY_IDX_W-1:0]   width
  );
    logic [PHY_MAX_W:0] w;
    w        = {1'b0, payload};
    w[width] = valid;
    return w;
  endfunction

endpackage

// File: rtl/bsg_link_osdr_credit_counter.sv
// Saturating up/down credit counter; overflow_o pulses when a return arrives at max_p.
module bsg_link_osdr_credit_counter
  import bsg_link_osdr_pkg::*;
#(
  parameter int max_p  = 8,
  parameter int init_p = max_p
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic up_i,
  input  logic down_i,
  input  logic reinit_i,
  output logic zero_o,
  output logic overflow_o
);

  localparam int CW = $clog2(max_p + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(max_p);
  localparam logic [CW-1:0] CNT_INIT = CW'(init_p);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d      = cnt_q;
    overflow_o = 1'b0;
    if (reinit_i) begin
      cnt_d = CNT_INIT;
    end else if (up_i & ~down_i) begin
      if (cnt_q == CNT_MAX) overflow_o = 1'b1;
      else                  cnt_d      = cnt_q + 1'b1;
    end else if (down_i & ~up_i & (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) cnt_q <= CNT_INIT;
    else            cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bsg_link_osdr_tx_sequencer.sv
// OSDR transmit sequencer: PHY reset, idle warm-up, then credit-gated payload transfer.
// width_p must be set by the instantiating design (must be below PHY_MAX_W).
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   PHY_RST | phy_reset_o high, idle words, credits held at credits_p
//   WARMUP  | PHY out of reset, idle words so receiver locks its clock
//   ACTIVE  | link up, payload sent while credits remain
module bsg_link_osdr_tx_sequencer
  import bsg_link_osdr_pkg::*;
#(
  parameter int width_p            = 8,
  parameter int credits_p          = 8,
  parameter int phy_reset_cycles_p = 4,
  parameter int warmup_cycles_p    = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               link_restart_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic               token_i,
  output logic               phy_reset_o,
  output logic [width_p:0]   phy_data_o,
  output logic               link_up_o,
  output logic               credit_err_o
);

  localparam int MAX_CYC = (phy_reset_cycles_p > warmup_cycles_p) ?
                           phy_reset_cycles_p : warmup_cycles_p;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(phy_reset_cycles_p - 1);
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(warmup_cycles_p - 1);

  bsg_link_osdr_tx_state_e state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [width_p:0]        data_q, data_d;
  logic                    err_q, err_d;

  logic credit_zero;
  logic credit_overflow;
  logic send;
  logic credit_reinit;

  // Restart masks ready so a coincident handshake never slips through.
  assign ready_o       = (state_q == ACTIVE) & ~credit_zero & ~link_restart_i;
  assign send          = v_i & ready_o;
  assign credit_reinit = link_restart_i | (state_q != ACTIVE);

  bsg_link_osdr_credit_counter #(
    .max_p  (credits_p),
    .init_p (credits_p)
  ) credit_ctr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .up_i       (token_i),
    .down_i     (send),
    .reinit_i   (credit_reinit),
    .zero_o     (credit_zero),
    .overflow_o (credit_overflow)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q | credit_overflow;
    data_d  = send ? (width_p+1)'(phy_word(1'b1,
                                           {{(PHY_MAX_W-width_p){1'b0}}, data_i},
                                           PHY_IDX_W'(width_p)))
                   : (width_p+1)'(PHY_IDLE_WORD);

    unique case (state_q)
      PHY_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WARMUP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WARMUP: begin
        if (cnt_q == WARM_LAST) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACTIVE: begin
        cnt_d = '0;
      end
      default: begin
        state_d = PHY_RST;
        cnt_d   = '0;
      end
    endcase

    if (link_restart_i) begin
      state_d = PHY_RST;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= PHY_RST;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign phy_reset_o  = (state_q == PHY_RST);
  assign link_up_o    = (state_q == ACTIVE);
  assign phy_data_o   = data_q;
  assign credit_err_o = err_q;

endmodule

// File: tb/tb_bsg_link_osdr_tx_sequencer.sv
// Scoreboard bench for the OSDR transmit sequencer: directed bring-up/credit cases plus random traffic.
module tb_bsg_link_osdr_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       restart;
  logic [7:0] data;
  logic       v;
  logic       ready;
  logic       token;
  logic       phy_reset;
  logic [8:0] phy_data;
  logic       link_up;
  logic       credit_err;

  int         tests = 0;
  int         fails = 0;
  logic [8:0] sb[$];
  logic [7:0] dnext = 8'h00;

  bsg_link_osdr_tx_sequencer #(
    .width_p            (8),
    .credits_p          (8),
    .phy_reset_cycles_p (4),
    .warmup_cycles_p    (16)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (rst_n),
    .link_restart_i (restart),
    .data_i         (data),
    .v_i            (v),
    .ready_o        (ready),
    .token_i        (token),
    .phy_reset_o    (phy_reset),
    .phy_data_o     (phy_data),
    .link_up_o      (link_up),
    .credit_err_o   (credit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid word must match the oldest expected word; idle words must be all zero.
  always @(negedge clk) begin
    if (phy_data[8] === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got %0h, required no word", phy_data);
      end else begin
        check("word", {23'd0, phy_data}, {23'd0, sb.pop_front()});
      end
    end else begin
      check("idle_word", {23'd0, phy_data}, 32'd0);
    end
  end

  // {phy_reset, link_up, ready, credit_err} over cycles 0..20 of bring-up.
  task automatic bringup(input string name, input logic err);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", name, k),
            {28'd0, phy_reset, link_up, ready, credit_err},
            {28'd0, (k < 4), (k >= 20), (k >= 20), err});
      @(posedge clk); #1;
    end
  endtask

  // One cycle of stimulus; a word is expected whenever the bench predicts a handshake.
  task automatic cyc(input logic vv, input logic tk, input logic exp_rdy, input string name);
    v     = vv;
    token = tk;
    data  = dnext;
    if (vv && exp_rdy) sb.push_back({1'b1, dnext});
    @(negedge clk);
    check(name, {31'd0, ready}, {31'd0, exp_rdy});
    @(posedge clk); #1;
    if (vv && exp_rdy) dnext = dnext + 8'd1;
  endtask

  initial begin
    int   cm;
    logic vv, tk;

    rst_n = 1'b0; restart = 1'b0; v = 1'b0; token = 1'b0; data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_state", {28'd0, phy_reset, link_up, ready, credit_err}, 32'b1000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bringup("bringup", 1'b0);

    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, i < 8, "exhaust_ready");
    cyc(1'b1, 1'b1, 1'b0, "token_at_zero");
    cyc(1'b1, 1'b0, 1'b1, "token_send");
    cyc(1'b1, 1'b0, 1'b0, "token_stall");
    cyc(1'b1, 1'b0, 1'b0, "token_stall2");

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, i > 0, "refill3");
    cyc(1'b1, 1'b1, 1'b1, "token_and_send");
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, i < 3, "after_both");

    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, i > 0, "refill8");
    v = 1'b0; token = 1'b1;
    @(negedge clk);
    check("err_before_ovf", {31'd0, credit_err}, 32'd0);
    @(posedge clk); #1;
    token = 1'b0;
    @(negedge clk);
    check("err_after_ovf", {31'd0, credit_err}, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, i < 8, "saturated_at_8");

    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, i > 0, "refill5");
    v = 1'b1; restart = 1'b1; data = dnext;
    @(negedge clk);
    check("restart_blocks_ready", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    restart = 1'b0; v = 1'b0;
    bringup("restart_bringup", 1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, i < 8, "credits_reinit");

    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, i > 0, "refill4");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, "burst");
    v = 1'b1; data = dnext; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; v = 1'b0;
    bringup("reset_bringup", 1'b0);

    cm = 8;
    for (int n = 0; n < 10000; n++) begin
      vv    = 1'($urandom_range(0, 1));
      tk    = (cm < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      dnext = 8'($urandom);
      cyc(vv, tk, cm != 0, "rand_ready");
      cm = cm + int'(tk) - int'(vv && (cm != 0));
    end

    v = 1'b0; token = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("err_final", {31'd0, credit_err}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
